// File: rtl/gray_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray_fifo_pkg : shared sizing helpers and Gray encoding for the       |
// |                 dual-clock channel FIFO pointer logic. Rev 1.0        |
// +----------------------------------------------------------------------+
package gray_fifo_pkg;

  localparam int unsigned C_MAX_PTR_W  = 32;
  localparam int unsigned C_ADDR_WIDTH = 3;
  localparam int unsigned C_DEPTH      = 1 << C_ADDR_WIDTH;
  localparam int unsigned C_PTR_WIDTH  = C_ADDR_WIDTH + 1;

  function automatic int unsigned ptr_width(input int unsigned aw);
    return aw + 1;
  endfunction

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 1 << aw;
  endfunction

  // Callers size-cast the result down to their own pointer width.
  function automatic logic [C_MAX_PTR_W-1:0] bin2gray(input logic [C_MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray_decoder : combinational Gray-to-binary conversion. Rev 1.0       |
// +----------------------------------------------------------------------+
module gray_decoder #(
  parameter int unsigned p_width = 4
) (
  input  logic [p_width-1:0] gray,
  output logic [p_width-1:0] bin
);

  // Each binary bit is the parity of all Gray bits at or above it.
  for (genvar i = 0; i < p_width; i++) begin : g_bit
    assign bin[i] = ^gray[p_width-1:i];
  end

endmodule
`default_nettype wire

// File: rtl/gray_ptr_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray_ptr_sync : multi-flop synchronizer for a Gray-coded pointer      |
// |                 crossing into this clock domain. Rev 1.0              |
// +----------------------------------------------------------------------+
module gray_ptr_sync #(
  parameter int unsigned p_width  = 4,
  parameter int unsigned p_stages = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [p_width-1:0] d_async,
  output logic [p_width-1:0] q_sync
);

  logic [p_width-1:0] sync_q [p_stages];
  logic [p_width-1:0] sync_d [p_stages];

  always_comb begin
    sync_d[0] = d_async;
    for (int i = 1; i < p_stages; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < p_stages; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_sync = sync_q[p_stages-1];

endmodule
`default_nettype wire

// File: rtl/gray_wptr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray_wptr_ctrl : write-side pointer controller of a dual-clock FIFO;  |
// |   optional sticky overflow flag under GRAY_WPTR_OVF_CHECK_EN. Rev 1.0 |
// +----------------------------------------------------------------------+
module gray_wptr_ctrl
  import gray_fifo_pkg::*;
#(
  parameter int unsigned p_addr_width  = 3,
  parameter int unsigned p_sync_stages = 2
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              enq_en,
  output logic                              enq_rdy,
  output logic                              wr_en,
  output logic [p_addr_width-1:0]           waddr,
  output logic [ptr_width(p_addr_width)-1:0] wptr_gray,
  input  logic [ptr_width(p_addr_width)-1:0] rptr_gray_async,
  output logic [ptr_width(p_addr_width)-1:0] count,
  output logic                              ovf_err
);

  localparam int unsigned P = ptr_width(p_addr_width);

  logic [P-1:0] wptr_bin_q,  wptr_bin_d;
  logic [P-1:0] wptr_gray_q, wptr_gray_d;
  logic [P-1:0] rsync;
  logic [P-1:0] rsync_bin;
  logic         full;
  logic         fire;

  gray_ptr_sync #(
    .p_width  (P),
    .p_stages (p_sync_stages)
  ) u_rptr_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_async (rptr_gray_async),
    .q_sync  (rsync)
  );

  gray_decoder #(
    .p_width (P)
  ) u_rptr_dec (
    .gray (rsync),
    .bin  (rsync_bin)
  );

  // Full when the pointers differ only in the wrap bit, compared in Gray space.
  assign full = (wptr_gray_q[P-1:P-2] == ~rsync[P-1:P-2]) &&
                (wptr_gray_q[P-3:0]   ==  rsync[P-3:0]);

  assign enq_rdy = ~full;
  assign fire    = enq_en & ~full;

  always_comb begin
    wptr_bin_d  = wptr_bin_q;
    wptr_gray_d = wptr_gray_q;
    if (fire) begin
      wptr_bin_d  = wptr_bin_q + 1'b1;
      wptr_gray_d = P'(bin2gray(C_MAX_PTR_W'(wptr_bin_d)));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_bin_q  <= '0;
      wptr_gray_q <= '0;
    end else begin
      wptr_bin_q  <= wptr_bin_d;
      wptr_gray_q <= wptr_gray_d;
    end
  end

  assign wr_en     = fire;
  assign waddr     = wptr_bin_q[p_addr_width-1:0];
  assign wptr_gray = wptr_gray_q;
  // Synchronized read pointer lags, so this may overstate occupancy but never understate it.
  assign count     = wptr_bin_q - rsync_bin;

`ifdef GRAY_WPTR_OVF_CHECK_EN
  logic ovf_err_q, ovf_err_d;

  always_comb begin
    ovf_err_d = ovf_err_q | (enq_en & full);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_err_q <= 1'b0;
    end else begin
      ovf_err_q <= ovf_err_d;
    end
  end

  assign ovf_err = ovf_err_q;
`else
  assign ovf_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_wptr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gray_wptr_ctrl : scoreboard bench for gray_wptr_ctrl. Rev 1.0      |
// +----------------------------------------------------------------------+
module tb_gray_wptr_ctrl;

  localparam int AW = 3;
  localparam int P  = 4;
`ifdef GRAY_WPTR_OVF_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enq_en = 1'b0;
  logic [P-1:0]  rptr_gray_async = '0;
  logic          enq_rdy;
  logic          wr_en;
  logic [AW-1:0] waddr;
  logic [P-1:0]  wptr_gray;
  logic [P-1:0]  count;
  logic          ovf_err;

  gray_wptr_ctrl #(
    .p_addr_width  (AW),
    .p_sync_stages (2)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enq_en          (enq_en),
    .enq_rdy         (enq_rdy),
    .wr_en           (wr_en),
    .waddr           (waddr),
    .wptr_gray       (wptr_gray),
    .rptr_gray_async (rptr_gray_async),
    .count           (count),
    .ovf_err         (ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rdy;
    logic       wr;
    logic       ovf;
    logic [2:0] waddr;
    logic [3:0] gray;
    logic [3:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: enqueue count, the read pointer values the write side will
  // see in the next two cycles, and the sticky overflow state.
  int   wcnt;
  int   rdelay[$];
  bit   ovf_m;
  int   rb;

  function automatic logic [3:0] to_gray(input int v);
    logic [3:0] b;
    b = v[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    wcnt   = 0;
    rdelay = '{0, 0};
    ovf_m  = 1'b0;
  endtask

  task automatic push_reset_exp();
    exp_t e;
    e.rdy = 1'b1; e.wr = 1'b0; e.ovf = 1'b0;
    e.waddr = '0; e.gray = '0; e.count = '0;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit en, input int rbin);
    int   occ;
    bit   rdy;
    bit   fire;
    exp_t e;
    @(posedge clk); #1;
    enq_en          = en;
    rptr_gray_async = to_gray(rbin);
    occ  = (wcnt - rdelay[0]) & 15;
    rdy  = (occ != 8);
    fire = en && rdy;
    e.rdy   = rdy;
    e.wr    = fire;
    e.ovf   = ovf_m;
    e.waddr = 3'(wcnt & 7);
    e.gray  = to_gray(wcnt);
    e.count = 4'(occ);
    exp_q.push_back(e);
    if (fire) wcnt = (wcnt + 1) & 15;
    if (OVF_EN && en && !rdy) ovf_m = 1'b1;
    void'(rdelay.pop_front());
    rdelay.push_back(rbin & 15);
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      reset_n         = 1'b0;
      enq_en          = 1'b0;
      rptr_gray_async = '0;
      push_reset_exp();
      model_reset();
    end
    @(negedge clk); #1;
    reset_n = 1'b1;
  endtask

  // Reset dropped between edges; outputs must clear before the next edge.
  task automatic midop_reset();
    @(posedge clk); #1;
    enq_en = 1'b0;
    #2;
    reset_n = 1'b0;
    push_reset_exp();
    model_reset();
    hold_reset(1);
  endtask

  exp_t mon_e;
  bit   mon_bad;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_bad = 1'b0;
      n_vec++;
      if (enq_rdy !== mon_e.rdy) begin
        $display("FAIL enq_rdy t=%0t got %b want %b", $time, enq_rdy, mon_e.rdy); mon_bad = 1'b1;
      end
      if (wr_en !== mon_e.wr) begin
        $display("FAIL wr_en t=%0t got %b want %b", $time, wr_en, mon_e.wr); mon_bad = 1'b1;
      end
      if (ovf_err !== mon_e.ovf) begin
        $display("FAIL ovf_err t=%0t got %b want %b", $time, ovf_err, mon_e.ovf); mon_bad = 1'b1;
      end
      if (waddr !== mon_e.waddr) begin
        $display("FAIL waddr t=%0t got %0d want %0d", $time, waddr, mon_e.waddr); mon_bad = 1'b1;
      end
      if (wptr_gray !== mon_e.gray) begin
        $display("FAIL wptr_gray t=%0t got %h want %h", $time, wptr_gray, mon_e.gray); mon_bad = 1'b1;
      end
      if (count !== mon_e.count) begin
        $display("FAIL count t=%0t got %0d want %0d", $time, count, mon_e.count); mon_bad = 1'b1;
      end
      if (mon_bad) n_err++;
    end
  end

  initial begin
    model_reset();
    hold_reset(2);

    // Fill from empty with the reader idle, one attempt past full.
    repeat (9) cycle(1'b1, 0);
    // Reader frees two entries; visible two cycles later. Overflow flag must hold.
    repeat (3) cycle(1'b0, 2);
    repeat (3) cycle(1'b0, 3);
    midop_reset();

    // Wrap: reader trails the writer so occupancy stays small across 15->0.
    repeat (3) cycle(1'b1, 0);
    for (int i = 0; i < 20; i++) begin
      rb = (wcnt - 1) & 15;
      cycle(1'b1, rb);
    end

    // Randomized traffic with a legal reader that never passes the writer.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        midop_reset();
        rb = 0;
      end
      if (((wcnt - rb) & 15) != 0 && $urandom_range(0, 2) != 0) rb = (rb + 1) & 15;
      cycle($urandom_range(0, 9) < 7, rb);
    end

    @(posedge clk); #1;
    enq_en = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      $display("FAIL drain pending=%0d want 0", exp_q.size());
      n_err++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
